// File: rtl/chan_mux_seq_if.sv
// Bus bundle for chan_mux_seq: per-channel operand words in, one
// registered word out under a valid/ready handshake, plus scan status.
interface chan_mux_seq_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      mode;
    logic                      in_valid;
    logic [SEL_W-1:0]          sel;
    logic                      start;
    logic [CHANNELS*WIDTH-1:0] d_in;
    logic                      out_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          data_out;
    logic [SEL_W-1:0]          chan_out;
    logic                      busy;
    logic                      done;

    modport master (
        output mode, in_valid, sel, start, d_in, out_ready,
        input  out_valid, data_out, chan_out, busy, done
    );

    modport slave (
        input  mode, in_valid, sel, start, d_in, out_ready,
        output out_valid, data_out, chan_out, busy, done
    );
endinterface

// File: rtl/chan_mux_seq.sv
// Registered N-channel word selector: direct per-request select or an
// automatic in-order scan of every channel, behind a 1-entry output register.
module chan_mux_seq #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    chan_mux_seq_if.slave bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WAIT
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] idx;
    logic             out_valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] chan_q;
    logic             busy_q;
    logic             done_q;

    logic             slot_free;
    logic             xfer;
    logic [SEL_W-1:0] pick;
    logic [WIDTH-1:0] pick_word;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign xfer      = out_valid_q && bus.out_ready;

    // Indices with no backing channel select zero rather than wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pick_word = '0;
        pick      = (state == S_SCAN) ? idx : bus.sel;
        for (int k = 0; k < CHANNELS; k++) begin
            if (pick == SEL_W'(k)) pick_word = bus.d_in[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data/channel registers are reset too, so data_out reads 0 out of reset.
            state       <= S_IDLE;
            idx         <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            chan_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: state is updated with <= only, so every branch sees pre-edge values.
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!bus.mode && bus.in_valid && slot_free) begin
                        out_valid_q <= 1'b1;
                        data_q      <= pick_word;
                        chan_q      <= bus.sel;
                    end else if (xfer) begin
                        out_valid_q <= 1'b0;
                    end
                    if (bus.mode && bus.start) begin
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    if (slot_free) begin
                        out_valid_q <= 1'b1;
                        data_q      <= pick_word;
                        chan_q      <= idx;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_WAIT;
                        end else begin
                            idx <= idx + SEL_W'(1);
                        end
                    end
                end

                S_WAIT: begin
                    // The final scan word must leave before done is signalled.
                    if (xfer) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.chan_out  = chan_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_chan_mux_seq.sv
// Self-checking bench for chan_mux_seq: directed scenarios plus random
// traffic against a transaction-level model built on a queue of pending scan indices.
module tb_chan_mux_seq;
    localparam int W  = 16;
    localparam int CH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chan_mux_seq_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
    chan_mux_seq #(.WIDTH(W), .CHANNELS(CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    chan_mux_seq_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();
    chan_mux_seq #(.WIDTH(8), .CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    chan_mux_seq_if #(.WIDTH(16), .CHANNELS(1)) bus1 ();
    chan_mux_seq #(.WIDTH(16), .CHANNELS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the output word, whether a scan is active, and the
    // channel indices that scan still owes downstream.
    bit         m_valid, m_busy, m_done, m_from_scan;
    logic [W-1:0] m_data;
    int         m_chan;
    int         scan_q[$];
    int         seen[$];

    function automatic logic [W-1:0] chan_word(input int k);
        return (k < CH) ? bus.d_in[k*W +: W] : '0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_busy = 0; m_done = 0; m_from_scan = 0;
        m_data = '0; m_chan = 0;
        scan_q.delete();
        seen.delete();
    endtask

    task automatic model_load(input int k, input bit from_scan);
        m_valid     = 1;
        m_data      = chan_word(k);
        m_chan      = k;
        m_from_scan = from_scan;
    endtask

    task automatic model_edge();
        bit xfer, free;
        if (!rst_n) begin
            model_reset();
            return;
        end
        xfer   = m_valid && bus.out_ready;
        free   = !m_valid || bus.out_ready;
        m_done = 0;
        if (!m_busy) begin
            if (!bus.mode && bus.in_valid && free) model_load(int'(bus.sel), 0);
            else if (xfer) m_valid = 0;
            if (bus.mode && bus.start) begin
                m_busy = 1;
                scan_q.delete();
                for (int k = 0; k < CH; k++) scan_q.push_back(k);
            end
        end else if (scan_q.size() != 0) begin
            if (free) model_load(scan_q.pop_front(), 1);
        end else if (xfer) begin
            m_valid = 0;
            m_done  = 1;
            m_busy  = 0;
        end
    endtask

    task automatic compare_all();
        check("out_valid", bus.out_valid, m_valid);
        check("data_out", bus.data_out, m_data);
        check("chan_out", bus.chan_out, m_chan);
        check("busy", bus.busy, m_busy);
        check("done", bus.done, m_done);
    endtask

    // Advance one clock: log the DUT transfer about to happen, update the
    // model at the edge, then compare just after it.
    task automatic step();
        if (rst_n && m_valid && m_from_scan && bus.out_valid && bus.out_ready)
            seen.push_back(int'(bus.chan_out));
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (m_done) begin
            check("scan_count", seen.size(), CH);
            for (int k = 0; k < seen.size() && k < CH; k++) check("scan_order", seen[k], k);
            seen.delete();
        end
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_data"}, bus.data_out, 0);
        check({tag, "_chan"}, bus.chan_out, 0);
        step();
        rst_n = 1'b1;
    endtask

    int  busy_cnt, done_cnt;
    bit  got_done;
    bit  ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        model_reset();
        bus.mode = 0; bus.in_valid = 0; bus.sel = '0; bus.start = 0; bus.out_ready = 0;
        bus.d_in = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
        bus3.mode = 0; bus3.in_valid = 0; bus3.sel = '0; bus3.start = 0; bus3.out_ready = 1;
        bus3.d_in = {8'h33, 8'h22, 8'h11};
        bus1.mode = 0; bus1.in_valid = 0; bus1.sel = '0; bus1.start = 0; bus1.out_ready = 1;
        bus1.d_in = 16'hBEEF;

        step();
        step();
        rst_n = 1'b1;

        // Reset mid-operation clears outputs without waiting for a clock.
        bus.in_valid = 1; bus.sel = 2'd1; bus.out_ready = 0;
        step();
        check("pre_rst_valid", bus.out_valid, 1);
        async_reset_check("rst_mid_direct");

        // Direct select, one-cycle latency.
        bus.in_valid = 1; bus.sel = 2'd2; bus.out_ready = 1;
        step();
        check("dir_data", bus.data_out, 16'h000C);
        check("dir_chan", bus.chan_out, 2);
        check("dir_valid", bus.out_valid, 1);

        // Back-pressure: the held word survives a sel change.
        bus.out_ready = 0; bus.sel = 2'd3;
        step();
        check("bp_hold_data", bus.data_out, 16'h000C);
        step();
        check("bp_hold_data2", bus.data_out, 16'h000C);
        bus.out_ready = 1;
        step();
        check("bp_release_data", bus.data_out, 16'h000D);
        check("bp_release_chan", bus.chan_out, 3);
        bus.in_valid = 0;
        step();

        // Full-rate scan.
        bus.mode = 1; bus.start = 1; bus.out_ready = 1;
        busy_cnt = 0; done_cnt = 0;
        for (int e = 0; e <= CH + 1; e++) begin
            step();
            bus.start = 0;
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.done);
            if (e >= 1 && e <= CH) begin
                check("scan_data", bus.data_out, 16'h000A + 16'(e - 1));
                check("scan_chan", bus.chan_out, e - 1);
            end
        end
        check("scan_busy_cycles", busy_cnt, CH + 1);
        check("scan_done_pulses", done_cnt, 1);
        check("scan_end_valid", bus.out_valid, 0);

        // Stalled scan.
        bus.start = 1;
        got_done = 0;
        for (int i = 0; i < 64 && !got_done; i++) begin
            bus.out_ready = ready_pat[i % 4];
            step();
            bus.start = 0;
            if (bus.done) got_done = 1;
        end
        check("stall_done_seen", got_done, 1);

        // Reset after ch1 has transferred.
        bus.out_ready = 1; bus.start = 1;
        step();
        bus.start = 0;
        step();
        step();
        step();
        check("pre_rst_chan", bus.chan_out, 2);
        async_reset_check("rst_mid_scan");
        check("rst_no_done", bus.done, 0);
        bus.start = 1;
        step();
        bus.start = 0;
        step();
        check("rescan_first_chan", bus.chan_out, 0);
        check("rescan_first_data", bus.data_out, 16'h000A);
        got_done = 0;
        for (int i = 0; i < 16 && !got_done; i++) begin
            step();
            if (bus.done) got_done = 1;
        end
        check("rescan_done_seen", got_done, 1);

        // Parameter corners: 3-channel out-of-range select, 1-channel scan.
        bus.mode = 0;
        bus3.in_valid = 1; bus3.sel = 2'd3;
        step();
        check("c3_oor_data", bus3.data_out, 8'h00);
        check("c3_oor_chan", bus3.chan_out, 3);
        check("c3_oor_valid", bus3.out_valid, 1);
        bus3.sel = 2'd2;
        step();
        check("c3_data", bus3.data_out, 8'h33);
        check("c3_chan", bus3.chan_out, 2);
        bus3.in_valid = 0;
        bus1.mode = 1; bus1.start = 1;
        step();
        bus1.start = 0;
        check("c1_busy", bus1.busy, 1);
        check("c1_idle_valid", bus1.out_valid, 0);
        step();
        check("c1_valid", bus1.out_valid, 1);
        check("c1_data", bus1.data_out, 16'hBEEF);
        check("c1_chan", bus1.chan_out, 0);
        check("c1_no_done", bus1.done, 0);
        step();
        check("c1_done", bus1.done, 1);
        check("c1_busy_low", bus1.busy, 0);
        check("c1_end_valid", bus1.out_valid, 0);
        step();
        check("c1_done_pulse", bus1.done, 0);

        // Random traffic, live channel data and occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.sel       = 2'($urandom_range(0, CH - 1));
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.d_in      = {$urandom(), $urandom()};
            if ($urandom_range(0, 249) == 0) async_reset_check("rst_rand");
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
